hand_frame_decoder: RTL
=======================

HAND_FRAME_DECODER -- requirements
Module: hand_frame_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 564, clk_in cycles per UART bit (65 MHz / 115200).
REQ-002 SHALL have parameter SYNC_LEN, default 3, number of consecutive 0xFF bytes that form the frame header.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65000, maximum idle clk_in cycles between payload bytes.
REQ-004 clk_in  input  1  single clock (65 MHz domain); all logic on its rising edge.
REQ-005 rst_in_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rxd_in  input  1  asynchronous UART line from the peer camera board (8N1, LSB first, idle high).
REQ-007 hand_x_top_out, hand_y_top_out  output  12 each  last decoded top-hand coordinates.
REQ-008 hand_x_bottom_out, hand_y_bottom_out  output  12 each  last decoded bottom-hand coordinates.
REQ-009 frame_valid_out  output  1  one-cycle pulse when all four coordinate outputs have been updated.
REQ-010 frame_err_out  output  1  one-cycle pulse when a frame is aborted.
REQ-011 err_count_out  output  8  saturating count of aborted frames.

Function
REQ-012 Byte receiver SHALL pass rxd_in through a 2-flop synchronizer and treat a high-to-low transition as a candidate start bit.
REQ-013 Start bit SHALL be re-sampled at CLKS_PER_BIT/2; if it is high, the candidate SHALL be discarded and the receiver SHALL return to idle.
REQ-014 Data bits SHALL be sampled at the centre of each bit, LSB first; the stop bit SHALL be sampled at its centre.
REQ-015 A byte SHALL be presented as a one-cycle byte_valid pulse with byte_err = (stop bit == 0).
REQ-016 Decoder FSM SHALL have states SYNC, PAYLOAD.
REQ-017 In SYNC, a 0xFF byte SHALL increment ff_cnt, saturating at SYNC_LEN.
REQ-018 In SYNC, a non-0xFF byte with ff_cnt < SYNC_LEN SHALL clear ff_cnt.
REQ-019 In SYNC, a non-0xFF byte with ff_cnt == SYNC_LEN SHALL be stored as payload byte 0, and the FSM SHALL go to PAYLOAD with idx = 1.
REQ-020 Payload byte order SHALL be: x_top[11:4], y_top[7:0], {x_top[3:0], y_top[11:8]}, x_bot[11:4], y_bot[7:0], {x_bot[3:0], y_bot[11:8]}.
REQ-021 In PAYLOAD, every byte SHALL be accepted (0xFF included) until 6 bytes are held.
REQ-022 On the 6th byte, outputs SHALL update and frame_valid_out SHALL pulse in the cycle after that byte_valid (latency 1); the FSM SHALL then return to SYNC with ff_cnt = 0.
REQ-023 Outputs SHALL hold their values between frames; partial frames SHALL never alter them.
REQ-024 A byte_err in PAYLOAD SHALL abort: pulse frame_err_out, increment err_count_out (saturating at 255), go to SYNC with ff_cnt = 0.
REQ-025 A byte_err in SYNC SHALL clear ff_cnt and SHALL NOT count as an error.
REQ-026 byte_valid and an abort condition in the same cycle SHALL resolve as abort; the byte SHALL be discarded.

Reset
REQ-027 While rst_in_n = 0: synchronizer flops SHALL be 1; FSM SHALL be SYNC; ff_cnt, idx and err_count SHALL be 0; all coordinate outputs SHALL be 0; pulses SHALL be 0.
REQ-028 Reset asserted mid-byte or mid-frame SHALL discard all partial data; after release, decoding SHALL restart at the next full header.

Configuration
REQ-029 With HAND_RX_TIMEOUT_EN defined, PAYLOAD SHALL count cycles since the last byte_valid.
REQ-030 With HAND_RX_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL abort exactly as in REQ-024.
REQ-031 Without HAND_RX_TIMEOUT_EN, no timeout counter SHALL exist and PAYLOAD SHALL wait indefinitely.

Structure
REQ-032 Package hand_link_pkg SHALL hold SYNC_BYTE (8'hFF), PAYLOAD_BYTES (6), COORD_W (12) and the FSM state enum; the peer transmitter SHALL use the same package.
REQ-033 Bit-level reception SHALL be sub-module uart_byte_rx (ports clk_in, rst_in_n, rxd_in, byte_out, byte_valid_out, byte_err_out); framing SHALL be in hand_frame_decoder.

Verification
REQ-034 Bytes FF FF FF 2A C3 51 13 F0 00 -> x_top = 0x2A5, y_top = 0x1C3, x_bot = 0x130, y_bot = 0x0F0; one frame_valid pulse.
REQ-035 Bytes FF FF 2A ... (short header), then a valid frame -> first 6 bytes ignored; only the second frame is decoded.
REQ-036 Payload FF FF FF 10 FF 2F 20 00 02 -> y_top = 0xFFF accepted; x_top = 0x102, x_bot = 0x200, y_bot = 0x200.
REQ-037 Stop bit forced 0 on payload byte 3 -> frame_err pulse; err_count = 1; outputs unchanged; next clean frame decodes.
REQ-038 Reset pulse after payload byte 2, then a full frame -> only post-reset frame decoded; err_count = 0.
REQ-039 With HAND_RX_TIMEOUT_EN defined, a line stall of TIMEOUT_CYC + 10 cycles after byte 1 -> frame_err pulse; without the macro -> no pulse, and the frame completes when transmission resumes.

Source files
------------

// File: rtl/hand_link_pkg.sv
// Shared definitions for the hand-coordinate UART link. The decoder and the peer
// transmitter both use this package.
package hand_link_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hFF;
  localparam int         PAYLOAD_BYTES = 6;
  localparam int         COORD_W       = 12;

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_PAYLOAD = 1'b1
  } hand_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x_top;
    logic [COORD_W-1:0] y_top;
    logic [COORD_W-1:0] x_bot;
    logic [COORD_W-1:0] y_bot;
  } hand_coords_t;

  // Byte 2 and byte 5 carry the low nibble of x and the high nibble of y.
  function automatic hand_coords_t unpack_payload(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] b4,
    input logic [7:0] b5
  );
    hand_coords_t c;
    c.x_top = {b0, b2[7:4]};
    c.y_top = {b2[3:0], b1};
    c.x_bot = {b3, b5[7:4]};
    c.y_bot = {b5[3:0], b4};
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first. Emits a one-cycle byte_valid_out pulse with
// byte_err_out flagging a low stop bit.
module uart_byte_rx
  import hand_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rxd_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       byte_err_out
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg, byte_reg;
  logic             valid_reg, err_reg;
  logic             start_edge, half_done, full_done;
  logic             cnt_clear, sample_data, finish_byte;

  assign start_edge = rx_prev_reg && !rx_sync_reg;
  assign half_done  = (cnt_reg == HALF_LAST);
  assign full_done  = (cnt_reg == FULL_LAST);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (start_edge) state_next = RX_START;
      // A line that is high again at mid-start was a glitch, not a start bit.
      RX_START: if (half_done) state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_done && bit_idx_reg == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (full_done) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_clear   = 1'b0;
    sample_data = 1'b0;
    finish_byte = 1'b0;
    case (state_reg)
      RX_IDLE:  cnt_clear = 1'b1;
      RX_START: cnt_clear = half_done;
      RX_DATA: begin
        cnt_clear   = full_done;
        sample_data = full_done;
      end
      RX_STOP: begin
        cnt_clear   = full_done;
        finish_byte = full_done;
      end
      default:  cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      rx_meta_reg <= rxd_in;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      cnt_reg     <= cnt_clear ? '0 : cnt_reg + CNT_W'(1);
      valid_reg   <= finish_byte;
      if (state_reg != RX_DATA) begin
        bit_idx_reg <= '0;
      end else if (sample_data) begin
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
      if (sample_data) begin
        shift_reg <= {rx_sync_reg, shift_reg[7:1]};
      end
      if (finish_byte) begin
        byte_reg <= shift_reg;
        err_reg  <= !rx_sync_reg;
      end
    end
  end

  assign byte_out       = byte_reg;
  assign byte_valid_out = valid_reg;
  assign byte_err_out   = err_reg;

endmodule

// File: rtl/hand_frame_decoder.sv
// Decodes SYNC_LEN x 0xFF + 6-byte hand-coordinate frames from the camera board UART.
// Define HAND_RX_TIMEOUT_EN to abort a frame whose payload stalls for TIMEOUT_CYC cycles.
module hand_frame_decoder
  import hand_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int SYNC_LEN     = 3,
  parameter int TIMEOUT_CYC  = 65000
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  input  logic               rxd_in,
  output logic [COORD_W-1:0] hand_x_top_out,
  output logic [COORD_W-1:0] hand_y_top_out,
  output logic [COORD_W-1:0] hand_x_bottom_out,
  output logic [COORD_W-1:0] hand_y_bottom_out,
  output logic               frame_valid_out,
  output logic               frame_err_out,
  output logic [7:0]         err_count_out
);

  localparam int FF_W  = $clog2(SYNC_LEN + 1);
  localparam int IDX_W = $clog2(PAYLOAD_BYTES);

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_err;

  hand_state_e      state_reg, state_next;
  logic [FF_W-1:0]  ff_cnt_reg, ff_cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       payload_reg [PAYLOAD_BYTES-1];
  hand_coords_t     coords_reg;
  logic             frame_valid_reg, frame_err_reg;
  logic [7:0]       err_count_reg;

  logic             is_sync_byte, header_done, last_byte, timeout_hit, abort;
  logic             store_en, frame_done, abort_evt;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .rxd_in         (rxd_in),
    .byte_out       (rx_byte),
    .byte_valid_out (rx_valid),
    .byte_err_out   (rx_err)
  );

  assign is_sync_byte = (rx_byte == SYNC_BYTE);
  assign header_done  = (ff_cnt_reg == FF_W'(SYNC_LEN));
  assign last_byte    = (idx_reg == IDX_W'(PAYLOAD_BYTES - 1));

`ifdef HAND_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_reg;

  assign timeout_hit = (state_reg == ST_PAYLOAD) && (idle_cnt_reg == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != ST_PAYLOAD || rx_valid) begin
      idle_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Abort wins over a byte arriving in the same cycle; that byte is dropped.
  assign abort = (state_reg == ST_PAYLOAD) && ((rx_valid && rx_err) || timeout_hit);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg  <= ST_SYNC;
      ff_cnt_reg <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ff_cnt_reg <= ff_cnt_next;
      idx_reg    <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SYNC: begin
        if (rx_valid && !rx_err && !is_sync_byte && header_done) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (abort || (rx_valid && last_byte)) state_next = ST_SYNC;
      end
      default: state_next = ST_SYNC;
    endcase
  end

  always_comb begin
    ff_cnt_next = ff_cnt_reg;
    idx_next    = idx_reg;
    store_en    = 1'b0;
    frame_done  = 1'b0;
    abort_evt   = 1'b0;
    case (state_reg)
      ST_SYNC: begin
        if (rx_valid) begin
          if (rx_err) begin
            ff_cnt_next = '0;
          end else if (is_sync_byte) begin
            if (!header_done) ff_cnt_next = ff_cnt_reg + FF_W'(1);
          end else if (header_done) begin
            store_en    = 1'b1;
            idx_next    = IDX_W'(1);
            ff_cnt_next = '0;
          end else begin
            ff_cnt_next = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (abort) begin
          abort_evt   = 1'b1;
          idx_next    = '0;
          ff_cnt_next = '0;
        end else if (rx_valid) begin
          store_en = 1'b1;
          if (last_byte) begin
            frame_done = 1'b1;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        idx_next    = '0;
        ff_cnt_next = '0;
      end
    endcase
  end

  // The final payload byte is taken straight from the receiver, so only five are held.
  genvar gi;
  generate
    for (gi = 0; gi < PAYLOAD_BYTES - 1; gi++) begin : g_payload
      always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
          payload_reg[gi] <= '0;
        end else if (store_en && idx_reg == IDX_W'(gi)) begin
          payload_reg[gi] <= rx_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      coords_reg      <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      frame_valid_reg <= frame_done;
      frame_err_reg   <= abort_evt;
      if (frame_done) begin
        coords_reg <= unpack_payload(payload_reg[0], payload_reg[1], payload_reg[2],
                                     payload_reg[3], payload_reg[4], rx_byte);
      end
      if (abort_evt && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign hand_x_top_out    = coords_reg.x_top;
  assign hand_y_top_out    = coords_reg.y_top;
  assign hand_x_bottom_out = coords_reg.x_bot;
  assign hand_y_bottom_out = coords_reg.y_bot;
  assign frame_valid_out   = frame_valid_reg;
  assign frame_err_out     = frame_err_reg;
  assign err_count_out     = err_count_reg;

endmodule
